// File: rtl/scan_link_pkg.sv
// Shared definitions for the scanner serial link (receiver and transmitter).
package scan_link_pkg;

  // Command codes carried in a command byte.
  localparam logic [7:0] CMD_BUF80   = 8'd2;
  localparam logic [7:0] CMD_BUF90   = 8'd3;
  localparam logic [7:0] CMD_BUFFULL = 8'd4;
  localparam logic [7:0] CMD_DATA    = 8'd7;

  // Receiver framing state: command byte or payload byte expected next.
  typedef enum logic {
    CMD,
    DATA
  } state_t;

  // Peer buffer fill level as reported by the scanner.
  typedef enum logic [1:0] {
    PEER_NONE = 2'd0,
    PEER_80   = 2'd1,
    PEER_90   = 2'd2,
    PEER_FULL = 2'd3
  } peer_level_t;

endpackage

// File: rtl/scan_link_sync.sv
// Two-flop synchronizer with a registered rising-edge detector.
module scan_link_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic sync1, sync2, sync2_q;

  // Synchronize the asynchronous input and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      sync2_q <= sync2;
    end
  end

  assign dout = sync2;
  assign rise = sync2 & ~sync2_q;

endmodule

// File: rtl/scan_link_receiver.sv
// Consumer side of the scanner serial link: bit assembly, command decode, payload capture.
import scan_link_pkg::*;

module scan_link_receiver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serClkIn,
  input  logic       serDataIn,
  input  logic       dataAccept,
  output logic       readyForTransferOut,
  output logic       cmdValid,
  output logic [7:0] cmdCode,
  output logic       dataValid,
  output logic [7:0] dataByte,
  output logic [1:0] peerLevel,
  output logic       cmdErr,
  output logic       frameErr,
  output logic       overflow
);

  logic             ser_clk_rise;
  logic             ser_clk_s;
  logic             data_s1, data_s2;
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt;
  logic [6:0]       shreg;
  logic [CNT_W-1:0] tmo_cnt;
  logic             byte_done, tmo_hit, tmo_run;
  logic [7:0]       rx_byte;
  peer_level_t      peer_q, peer_d;
  logic             cmd_valid_d, cmd_err_d, frame_err_d, data_valid_d, overflow_d;
  logic [7:0]       cmd_code_d, data_byte_d;

  // Clock line: synchronizer plus edge detect. The synchronized level itself is not needed.
  scan_link_sync u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (serClkIn),
    .dout (ser_clk_s),
    .rise (ser_clk_rise)
  );

  // Data line: synchronizer only, aligned with the clock line's synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      data_s1 <= serDataIn;
      data_s2 <= data_s1;
    end
  end

  // Bytes arrive LSB first: shift in at the top, the 8th bit completes the byte directly.
  assign byte_done = ser_clk_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {data_s2, shreg};
  assign tmo_run   = (bit_cnt != 3'd0) || (state_q == DATA);
  assign tmo_hit   = !ser_clk_rise && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Shift register, bit counter and mid-frame inactivity counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the shift register is a small flop bank, so it is reset along with the control state.
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else if (ser_clk_rise) begin
      shreg   <= {data_s2, shreg[6:1]};
      bit_cnt <= bit_cnt + 3'd1;
      tmo_cnt <= '0;
    end else if (tmo_hit) begin
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else if (tmo_run) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Framing state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CMD;
    else     state_q <= state_d;
  end

  // Next state and next output values: command decode, payload capture, handshake, abort.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    state_d      = state_q;
    cmd_valid_d  = 1'b0;
    cmd_err_d    = 1'b0;
    frame_err_d  = 1'b0;
    cmd_code_d   = cmdCode;
    peer_d       = peer_q;
    data_valid_d = dataValid & ~dataAccept;
    data_byte_d  = dataByte;
    overflow_d   = overflow;
    if (byte_done) begin
      if (state_q == CMD) begin
        unique case (rx_byte)
          CMD_BUF80:   begin peer_d = PEER_80;   cmd_valid_d = 1'b1; cmd_code_d = rx_byte; end
          CMD_BUF90:   begin peer_d = PEER_90;   cmd_valid_d = 1'b1; cmd_code_d = rx_byte; end
          CMD_BUFFULL: begin peer_d = PEER_FULL; cmd_valid_d = 1'b1; cmd_code_d = rx_byte; end
          CMD_DATA:    begin state_d = DATA;     cmd_valid_d = 1'b1; cmd_code_d = rx_byte; end
          default:     cmd_err_d = 1'b1;
        endcase
      end else begin
        // A payload landing in the same cycle as an accept replaces the taken byte cleanly.
        data_byte_d  = rx_byte;
        data_valid_d = 1'b1;
        peer_d       = PEER_NONE;
        state_d      = CMD;
        if (dataValid && !dataAccept) overflow_d = 1'b1;
      end
    end else if (tmo_hit) begin
      state_d     = CMD;
      frame_err_d = 1'b1;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmdValid  <= 1'b0;
      cmdErr    <= 1'b0;
      frameErr  <= 1'b0;
      cmdCode   <= 8'd0;
      peer_q    <= PEER_NONE;
      dataValid <= 1'b0;
      dataByte  <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      cmdValid  <= cmd_valid_d;
      cmdErr    <= cmd_err_d;
      frameErr  <= frame_err_d;
      cmdCode   <= cmd_code_d;
      peer_q    <= peer_d;
      dataValid <= data_valid_d;
      dataByte  <= data_byte_d;
      overflow  <= overflow_d;
    end
  end

  assign peerLevel           = peer_q;
  assign readyForTransferOut = ~dataValid & ~rst;

  // The synchronized clock level is only consumed through its edge detector.
  logic unused_ok;
  assign unused_ok = ser_clk_s;

endmodule

// File: doc/scan_link_receiver.md
# scan_link_receiver

Receiving end of the scanner serial link: recovers the scanner's gated serial clock and data line, assembles 8-bit LSB-first bytes, decodes command codes, and captures the payload byte that follows a data-transfer command. It sits on the consumer side of the link. It tracks the peer buffer level, presents received data to a local sink through a valid/accept handshake, and drives the scanner's ready-for-transfer input.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: `clk` cycles with no serial-clock rising edge, mid-frame, before the partial frame is aborted.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports (one clock, `clk`; reset `rst` is asynchronous, active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- serClkIn  in  1  gated serial clock from the scanner; asynchronous to `clk`.
- serDataIn  in  1  serial data from the scanner; valid at `serClkIn` rising edge.
- dataAccept  in  1  local sink takes `dataByte` while `dataValid` is high.
- readyForTransferOut  out  1  drives the scanner's ready-for-transfer input; equals ~dataValid & ~rst.
- cmdValid  out  1  one-cycle pulse when a known command byte completes.
- cmdCode  out  8  last completed command byte; holds its value between pulses.
- dataValid  out  1  level; payload byte is pending.
- dataByte  out  8  payload byte.
- peerLevel  out  2  0 none, 1 80%, 2 90%, 3 full.
- cmdErr  out  1  one-cycle pulse on an unknown command code.
- frameErr  out  1  one-cycle pulse on a timeout abort.
- overflow  out  1  sticky; set when a payload arrives while `dataValid` is already high; cleared only by reset.

## Operation
- Input path: `serClkIn` and `serDataIn` each pass through a 2-flop synchronizer. A rising edge is detected on the synchronized clock (previous 0, current 1). The bit taken is the synchronized data sampled in the same cycle as the detected edge.
- Shift register: bit k of a byte is the k-th edge, counting from 0, so bytes are LSB first. A 3-bit bit counter wraps after 8 edges, marking byte complete.
- States:
  - CMD: receiving a command byte.
  - DATA: receiving a payload byte.
- Command decode, on byte complete in CMD (codes are constants in the package):
  - 2 (BUF80): peerLevel=1, cmdValid pulse, stay in CMD.
  - 3 (BUF90): peerLevel=2, cmdValid pulse, stay in CMD.
  - 4 (BUFFULL): peerLevel=3, cmdValid pulse, stay in CMD.
  - 7 (DATA): cmdValid pulse, go to DATA.
  - any other value: cmdErr pulse, cmdCode unchanged, stay in CMD.
- Byte complete in DATA:
  - dataByte takes the shifted byte, dataValid=1, peerLevel=0, return to CMD.
  - If dataValid was already 1: overflow=1 and the new byte overwrites dataByte.
- Handshake: dataValid clears in the cycle after dataValid & dataAccept are both high. If a new payload completes in that same cycle, the new byte wins: dataValid stays 1 and overflow is not set.
- Timeout: a counter resets on every detected edge and increments while the bit counter is nonzero or the state is DATA. When it reaches TIMEOUT_CYCLES:
  - bit counter cleared, state forced to CMD, frameErr pulse;
  - peerLevel and dataValid are unchanged.
  - In CMD with the bit counter at 0, the counter holds at 0 (idle line is legal).

## Timing
- Reset values:
  - outputs: all outputs 0, except readyForTransferOut, which is 1 once reset deasserts;
  - internal: state CMD, counters 0, synchronizers 0.
- Edge-to-bit latency: 3 `clk` cycles from a `serClkIn` rise to the bit entering the shift register (2 synchronizer flops plus the edge-detect register).
- cmdValid, cmdErr and dataValid rise 1 cycle after the detect cycle of the 8th edge.
- Minimum serial clock: high and low phases each ≥ 2 `clk` periods. Faster input is unsupported.
- Reset mid-frame discards the partial byte with no error pulse.

## Structure
- Package `scan_link_pkg` holds:
  - command code localparams: CMD_BUF80=8'd2, CMD_BUF90=8'd3, CMD_BUFFULL=8'd4, CMD_DATA=8'd7;
  - the state enum {CMD, DATA};
  - the peerLevel encodings.
  The scanner-side transmitter shares this package.
- Sub-module `scan_link_sync`: 2-flop synchronizer plus rising-edge detector, instantiated for the clock line. The data line uses its synchronizer output only.

## Test plan
- Send byte 8'd2 LSB first, each serial phase 4 `clk` -> one cmdValid pulse, cmdCode=2, peerLevel=1.
- Send 8'd7 then 8'hA5, with dataAccept low -> cmdValid once, then dataValid=1, dataByte=A5, peerLevel=0, readyForTransferOut=0. Raise dataAccept -> dataValid=0 next cycle.
- Send 8'd9 -> cmdErr pulse, no cmdValid, cmdCode holds its previous value.
- Send 3 bits, then stall 64 cycles -> frameErr pulse. A following full 8'd4 decodes correctly, peerLevel=3.
- Two DATA frames (0x11, 0x22) with dataAccept held low -> overflow=1, dataByte=22.
- Assert rst after 5 bits of a command -> all outputs reset. A following 8'd3 yields cmdValid and peerLevel=2.
